// File: rtl/bus_pkg.sv
// bus_pkg: shared state encoding, bus-select codes and default limits for the bus arbiter
package bus_pkg;
  typedef enum logic [2:0] {IDLE, ACQ, GRANT, GAP, REL} state_t;
  localparam logic [1:0] SEL_CPU  = 2'b00;
  localparam logic [1:0] SEL_M0   = 2'b01;
  localparam logic [1:0] SEL_M1   = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;
  localparam int MAX_HOLD_DEF    = 64;
  localparam int ACK_TIMEOUT_DEF = 1023;
endpackage

// File: rtl/bus_arb_rr.sv
// bus_arb_rr: 2-way round-robin picker, a lone request wins outright, a tie goes to rr
module bus_arb_rr (
  input  logic [1:0] req,
  input  logic       rr,
  output logic [1:0] win
);
  // one-hot winner; rr=1 favours M1 on a tie
  always_comb win = (req == 2'b11) ? (rr ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: borrows the TV80 bus via BUSRQ/BUSAK and shares it between two masters
module bus_arbiter import bus_pkg::*; #(
  parameter int MAX_HOLD    = MAX_HOLD_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [1:0] REQ,
  output logic [1:0] GNT,
  output logic       nBUSRQ,
  input  logic       nBUSAK,
  output logic [1:0] BUS_SEL,
  output logic       ERR
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [TW-1:0] TMO_MAX  = TW'(ACK_TIMEOUT);
  if (MAX_HOLD < 1 || ACK_TIMEOUT < 1) begin : g_bad_param
    $error("bus_arbiter: MAX_HOLD and ACK_TIMEOUT must be at least 1");
  end
  state_t state, nxt;
  logic [HW-1:0] hold, hold_n, hold_inc;
  logic [TW-1:0] tmo, tmo_n, tmo_inc;
  logic own, own_n, rr, rr_n, err_n, nbusrq_n, enter_grant;
  logic [1:0] pick_req, win, gnt_n, sel_n;
  // in GAP only the master that did not just own the bus may win
  assign pick_req = (state == GAP) ? (REQ & (own ? 2'b01 : 2'b10)) : REQ;
  bus_arb_rr u_rr (
    .req (pick_req),
    .rr  (rr),
    .win (win)
  );
  // next state, counters and next registered outputs
  always_comb begin
    nxt = state;
    hold_n = '0;
    tmo_n = '0;
    err_n = ERR;
    tmo_inc = tmo + 1'b1;
    hold_inc = (hold == HOLD_MAX) ? hold : hold + 1'b1;
    case (state)
      IDLE: nxt = |REQ ? ACQ : IDLE;
      ACQ:
        if (!nBUSAK) nxt = |REQ ? GRANT : REL;
        else if (tmo_inc == TMO_MAX) begin
          nxt = REL;
          err_n = 1'b1;
        end else tmo_n = tmo_inc;
      GRANT:
        if (!REQ[own] || (hold_inc == HOLD_MAX && REQ[~own])) nxt = GAP;
        else hold_n = hold_inc;
      GAP: nxt = REQ[~own] ? GRANT : REL;
      REL:
        if (nBUSAK) nxt = IDLE;
        else if (tmo_inc == TMO_MAX) begin
          nxt = IDLE;
          err_n = 1'b1;
        end else tmo_n = tmo_inc;
      default: nxt = IDLE;
    endcase
    enter_grant = (nxt == GRANT) && (state != GRANT);
    own_n = enter_grant ? win[1] : own;
    rr_n = enter_grant ? win[0] : rr;
    nbusrq_n = !(nxt == ACQ || nxt == GRANT || nxt == GAP);
    gnt_n = (nxt == GRANT) ? (own_n ? 2'b10 : 2'b01) : 2'b00;
    sel_n = (nxt == IDLE) ? SEL_CPU : (nxt == GRANT) ? (own_n ? SEL_M1 : SEL_M0) : SEL_NONE;
  end
  // state, counters and all outputs are registered; CLR forces the CPU to own the bus
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state <= IDLE;
      hold <= '0;
      tmo <= '0;
      own <= 1'b0;
      rr <= 1'b0;
      ERR <= 1'b0;
      nBUSRQ <= 1'b1;
      GNT <= 2'b00;
      BUS_SEL <= SEL_CPU;
    end else begin
      state <= nxt;
      hold <= hold_n;
      tmo <= tmo_n;
      own <= own_n;
      rr <= rr_n;
      ERR <= err_n;
      nBUSRQ <= nbusrq_n;
      GNT <= gnt_n;
      BUS_SEL <= sel_n;
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scoreboard bench for bus_arbiter with MAX_HOLD=4, ACK_TIMEOUT=8
module tb_bus_arbiter;
  logic CLK = 1'b0;
  logic CLR, nBUSAK;
  logic [1:0] REQ;
  logic [1:0] GNT, BUS_SEL;
  logic nBUSRQ, ERR;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [1:0] prev_sel = 2'b00;
  logic [5:0] act;
  typedef struct {
    int cyc;
    string nm;
    logic [5:0] v;
  } exp_t;
  exp_t sbq[$];

  bus_arbiter #(.MAX_HOLD(4), .ACK_TIMEOUT(8)) dut (
    .CLK     (CLK),
    .CLR     (CLR),
    .REQ     (REQ),
    .GNT     (GNT),
    .nBUSRQ  (nBUSRQ),
    .nBUSAK  (nBUSAK),
    .BUS_SEL (BUS_SEL),
    .ERR     (ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // expected {nBUSRQ, GNT, BUS_SEL, ERR} for the current cycle
  task automatic chk(input string nm, input logic nb, input logic [1:0] g, input logic [1:0] s, input logic e);
    sbq.push_back('{cyc, nm, {nb, g, s, e}});
  endtask

  // monitor: compares queued expectations and the continuous bus-safety properties
  always @(negedge CLK) begin
    act = {nBUSRQ, GNT, BUS_SEL, ERR};
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      checks++;
      if (sbq[0].cyc != cyc || act !== sbq[0].v) begin
        errors++;
        $display("FAIL %s: got nBUSRQ/GNT/SEL/ERR=%b want %b (cycle %0d)", sbq[0].nm, act, sbq[0].v, cyc);
      end
      void'(sbq.pop_front());
    end
    checks++;
    if (GNT == 2'b11) begin
      errors++;
      $display("FAIL gnt_onehot: got GNT=%b want at most one bit (cycle %0d)", GNT, cyc);
    end
    checks++;
    if ((prev_sel == 2'b01 && BUS_SEL == 2'b10) || (prev_sel == 2'b10 && BUS_SEL == 2'b01)) begin
      errors++;
      $display("FAIL sel_gap: got BUS_SEL %b->%b want 11 in between (cycle %0d)", prev_sel, BUS_SEL, cyc);
    end
    prev_sel = BUS_SEL;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    CLR = 1'b1;
    REQ = 2'b00;
    nBUSAK = 1'b1;
    tick(2); chk("reset", 1, 2'b00, 2'b00, 0);
    CLR = 1'b0;
    REQ = 2'b01;
    tick(1); chk("to_acq", 0, 2'b00, 2'b11, 0);
    tick(7); chk("to_acq_8th", 0, 2'b00, 2'b11, 0);
    tick(1); chk("to_err", 1, 2'b00, 2'b11, 1);
    REQ = 2'b00;
    tick(1); chk("to_idle", 1, 2'b00, 2'b00, 1);
    tick(1); chk("err_sticky", 1, 2'b00, 2'b00, 1);
    REQ = 2'b11;
    tick(1); chk("sim_acq", 0, 2'b00, 2'b11, 1);
    nBUSAK = 1'b0;
    tick(1); chk("sim_m0", 0, 2'b01, 2'b01, 1);
    REQ = 2'b10;
    tick(1); chk("sim_gap", 0, 2'b00, 2'b11, 1);
    tick(1); chk("sim_m1", 0, 2'b10, 2'b10, 1);
    CLR = 1'b1;
    REQ = 2'b00;
    nBUSAK = 1'b1;
    tick(1); chk("rst_grant", 1, 2'b00, 2'b00, 0);
    CLR = 1'b0;
    tick(1); chk("rst_idle", 1, 2'b00, 2'b00, 0);
    REQ = 2'b01;
    tick(1); chk("one_acq", 0, 2'b00, 2'b11, 0);
    tick(2); chk("one_wait", 0, 2'b00, 2'b11, 0);
    nBUSAK = 1'b0;
    tick(1); chk("one_m0", 0, 2'b01, 2'b01, 0);
    tick(2); chk("one_hold", 0, 2'b01, 2'b01, 0);
    REQ = 2'b00;
    tick(1); chk("one_gap", 0, 2'b00, 2'b11, 0);
    tick(1); chk("one_rel", 1, 2'b00, 2'b11, 0);
    REQ = 2'b10;
    tick(1); chk("rel_holdoff", 1, 2'b00, 2'b11, 0);
    nBUSAK = 1'b1;
    tick(1); chk("one_idle", 1, 2'b00, 2'b00, 0);
    tick(1); chk("late_acq", 0, 2'b00, 2'b11, 0);
    nBUSAK = 1'b0;
    tick(1); chk("late_m1", 0, 2'b10, 2'b10, 0);
    REQ = 2'b00;
    tick(2); chk("late_rel", 1, 2'b00, 2'b11, 0);
    nBUSAK = 1'b1;
    tick(1); chk("late_idle", 1, 2'b00, 2'b00, 0);
    REQ = 2'b01;
    tick(1); chk("pre_acq", 0, 2'b00, 2'b11, 0);
    nBUSAK = 1'b0;
    tick(1); chk("pre_m0", 0, 2'b01, 2'b01, 0);
    REQ = 2'b11;
    tick(3); chk("pre_m0_4th", 0, 2'b01, 2'b01, 0);
    tick(1); chk("pre_gap", 0, 2'b00, 2'b11, 0);
    tick(1); chk("pre_m1", 0, 2'b10, 2'b10, 0);
    tick(1); chk("pre_m1_hold", 0, 2'b10, 2'b10, 0);
    REQ = 2'b01;
    tick(1); chk("pre_gap2", 0, 2'b00, 2'b11, 0);
    tick(1); chk("pre_regrant", 0, 2'b01, 2'b01, 0);
    REQ = 2'b00;
    tick(2); chk("rel_stuck", 1, 2'b00, 2'b11, 0);
    tick(7); chk("rel_7", 1, 2'b00, 2'b11, 0);
    tick(1); chk("rel_timeout", 1, 2'b00, 2'b00, 1);
    nBUSAK = 1'b1;
    for (int i = 0; i < 5 && sbq.size() > 0; i++) begin
      @(negedge CLK);
      #1;
    end
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked expectations want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
